mem_stage_sram: RTL and testbench
=================================

// Module: mem_stage_sram
// PURPOSE
//  Memory stage, directly downstream of the execute stage register. Consumes alu_out/Val_Rm/dest/ctrl,
//  performs loads/stores over a req/ready SRAM handshake, stalls the pipeline via freeze while busy,
//  and owns the MEM/WB pipeline register that feeds writeback.
// PARAMETERS
//  ADDR_W       16    SRAM word-address width
//  BASE_ADDR    1024  byte address mapped to SRAM word 0 (used only with MEM_BASE_OFFSET_EN)
//  TIMEOUT      255   max cycles in BUSY awaiting sram_ready before abort
// PORTS
//  clk              in   1      clock, all state on rising edge
//  rst              in   1      synchronous, active-high reset
//  wb_enable        in   1      from EXE reg: instruction writes a register
//  mem_read_enable  in   1      from EXE reg: load
//  mem_write_enable in   1      from EXE reg: store
//  dest             in   4      destination register index
//  alu_out          in   32     byte address (mem ops) or ALU result
//  Val_Rm           in   32     store data
//  sram_rdata       in   32     read data, valid when sram_ready=1
//  sram_ready       in   1      SRAM completes current access
//  freeze           out  1      combinational stall to PC/IF/ID/EXE regs
//  sram_req         out  1      registered access request
//  sram_we          out  1      1=write, 0=read; valid with sram_req
//  sram_addr        out  ADDR_W word address
//  sram_wdata       out  32     store data
//  wb_enable_out    out  1      MEM/WB reg
//  mem_read_out     out  1      MEM/WB reg: select mem_data_out in WB mux
//  dest_out         out  4      MEM/WB reg
//  alu_result_out   out  32     MEM/WB reg
//  mem_data_out     out  32     MEM/WB reg: load data
//  mem_err          out  1      sticky timeout flag
// BEHAVIOUR
//  - Reset: state=IDLE, all registered outputs 0 (sram_req, sram_we, sram_addr, sram_wdata, MEM/WB fields,
//    mem_err, timeout counter); reset mid-BUSY aborts access, no MEM/WB update.
//  - mem_op = mem_read_enable | mem_write_enable; both set: read wins, write dropped.
//  - IDLE: mem_op=0 -> MEM/WB loads inputs next edge (1-cycle pass-through), freeze=0.
//    mem_op=1 -> freeze=1, next edge: BUSY, sram_req=1, sram_we=~mem_read_enable, addr/wdata latched.
//  - BUSY: sram_req/we/addr/wdata held stable; freeze = ~sram_ready & ~timeout_hit.
//    sram_ready=1 -> edge: MEM/WB loads inputs, mem_data_out=sram_rdata (reads; 0 on writes),
//    sram_req=0, state=IDLE. Min load/store latency 2 cycles.
//  - Timeout: counter increments each BUSY cycle, cleared on entry; count==TIMEOUT -> treat as
//    completion with mem_data_out=0, wb_enable_out=0, mem_err<=1 (sticky until rst).
//  - Whenever freeze=1 MEM/WB loads a bubble (wb_enable_out=0, mem_read_out=0) -> no double writeback.
//  - sram_ready while IDLE ignored. Upstream inputs assumed stable while freeze=1.
// CONFIGURATION
//  MEM_BASE_OFFSET_EN defined: sram_addr = ((alu_out - BASE_ADDR) >> 2) truncated to ADDR_W.
//  undefined: sram_addr = alu_out[ADDR_W+1:2]; BASE_ADDR unused.
// STRUCTURE
//  mem_stage_pkg: state enum {IDLE, BUSY}, default ADDR_W/BASE_ADDR/TIMEOUT constants.
//  Sub-module mem_wb_reg: MEM/WB register with load/bubble control; FSM + SRAM I/O stay top level.
// TESTING
//  1. ALU op (wb=1, dest=3, alu_out=0x55) -> next cycle wb_enable_out=1, dest_out=3, alu_result_out=0x55, freeze never 1.
//  2. Load alu_out=1032, ready after 3 BUSY cycles, rdata=0xDEADBEEF -> req=1 we=0 addr=2 (offset build),
//     freeze high 4 cycles, then mem_data_out=0xDEADBEEF, mem_read_out=1, single WB pulse.
//  3. Store alu_out=1024 Val_Rm=0x1234, ready 1st BUSY cycle -> we=1 addr=0 wdata=0x1234, 2-cycle stall, wb_enable_out=0.
//  4. Load, sram_ready never -> freeze drops after TIMEOUT BUSY cycles, mem_err=1 stays, wb_enable_out=0.
//  5. rst asserted 2nd BUSY cycle -> next edge req=0, state IDLE, all outputs 0, freeze=0.
//  6. Read+write both set, and sram_ready pulsed in IDLE -> read issued (we=0); IDLE ready causes no change.

Source files
------------

// File: rtl/mem_stage_sram_pkg.sv
// Shared types and defaults for the memory stage.
//   state_e      FSM encoding: StIdle waits for a memory op, StBusy owns the SRAM handshake
//   Def*         default values of the ADDR_W / BASE_ADDR / TIMEOUT parameters
//   cnt_width()  width of a counter that must reach max_count
package mem_stage_sram_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefBaseAddr = 1024;
  localparam int unsigned DefTimeout  = 255;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_stage_sram_if.sv
// SRAM request/ready bus between the memory stage and the SRAM.
//   sram_req    request, held high until sram_ready
//   sram_we     1 = write, 0 = read; valid with sram_req
//   sram_addr   word address
//   sram_wdata  store data
//   sram_rdata  load data, valid when sram_ready = 1
//   sram_ready  SRAM completes the current access
// master: memory stage side; slave: SRAM side.
interface mem_stage_sram_if
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) ();

  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_ready;

  modport master (
    output sram_req,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata,
    input  sram_ready
  );

  modport slave (
    input  sram_req,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata,
    output sram_ready
  );

endinterface

// File: rtl/mem_stage_sram_mem_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst                 clock, synchronous active-high reset
//   load                     1: capture the incoming fields; 0: capture a bubble (all zero)
//   wb_enable, mem_read,
//   dest, alu_result,
//   mem_data                 next values of the MEM/WB fields
//   *_out                    registered MEM/WB fields feeding writeback
module mem_stage_sram_mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        wb_enable,
  input  logic        mem_read,
  input  logic [3:0]  dest,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_data,
  output logic        wb_enable_out,
  output logic        mem_read_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out
);

  always_ff @(posedge clk) begin
    if (rst || !load) begin
      wb_enable_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      dest_out       <= '0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
    end else begin
      wb_enable_out  <= wb_enable;
      mem_read_out   <= mem_read;
      dest_out       <= dest;
      alu_result_out <= alu_result;
      mem_data_out   <= mem_data;
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage: performs loads/stores over a req/ready SRAM bus, stalls upstream via freeze while
// an access is outstanding, and owns the MEM/WB register.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wb_enable, mem_read_enable,
//   mem_write_enable, dest,
//   alu_out, Val_Rm                   from the EXE register (held stable while freeze = 1)
//   sram                              SRAM bus (master side)
//   freeze                            combinational stall to PC/IF/ID/EXE registers
//   wb_enable_out, mem_read_out,
//   dest_out, alu_result_out,
//   mem_data_out                      MEM/WB register
//   mem_err                           sticky access-timeout flag
// Build option: define MEM_BASE_OFFSET_EN to subtract BASE_ADDR from the byte address before
// converting to a word address; otherwise the word address is alu_out[ADDR_W+1:2].
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned BASE_ADDR = DefBaseAddr,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_enable,
  input  logic                 mem_read_enable,
  input  logic                 mem_write_enable,
  input  logic [3:0]           dest,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          Val_Rm,
  mem_stage_sram_if.master     sram,
  output logic                 freeze,
  output logic                 wb_enable_out,
  output logic                 mem_read_out,
  output logic [3:0]           dest_out,
  output logic [31:0]          alu_result_out,
  output logic [31:0]          mem_data_out,
  output logic                 mem_err
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

`ifdef MEM_BASE_OFFSET_EN
  localparam logic [31:0] AddrOffset = 32'(BASE_ADDR);
`else
  localparam logic [31:0] AddrOffset = 32'd0;
`endif

  // The SRAM is word addressed; an unaligned base would make the mapping ambiguous.
  if (BASE_ADDR % 4 != 0) begin : g_base_check
    $error("BASE_ADDR must be word aligned");
  end

  state_e            st_q;
  logic [CntW-1:0]   cnt_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              mem_op;
  logic              timeout_hit;
  logic              busy_done;
  logic [ADDR_W-1:0] word_addr;

  logic              wb_load;
  logic              wb_en_d;
  logic              mem_read_d;
  logic [31:0]       mem_data_d;

  assign mem_op      = mem_read_enable | mem_write_enable;
  assign timeout_hit = (st_q == StBusy) && (cnt_q == TimeoutCnt);
  assign busy_done   = (st_q == StBusy) && (sram.sram_ready || timeout_hit);
  assign word_addr   = ADDR_W'((alu_out - AddrOffset) >> 2);

  assign freeze = ((st_q == StIdle) && mem_op) ||
                  ((st_q == StBusy) && !sram.sram_ready && !timeout_hit);

  // Control FSM with registered SRAM outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (mem_op) begin
            st_q    <= StBusy;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            // A simultaneous read+write request is treated as a read.
            we_q    <= ~mem_read_enable;
            addr_q  <= word_addr;
            wdata_q <= Val_Rm;
          end
        end
        StBusy: begin
          if (busy_done) begin
            st_q  <= StIdle;
            req_q <= 1'b0;
            // A ready arriving on the timeout cycle still counts as a good completion.
            if (!sram.sram_ready) err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign sram.sram_req   = req_q;
  assign sram.sram_we    = we_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = wdata_q;
  assign mem_err         = err_q;

  // MEM/WB next value: pass-through for non-memory ops, result on completion, bubble otherwise.
  always_comb begin
    wb_load    = 1'b0;
    wb_en_d    = wb_enable;
    mem_read_d = mem_read_enable;
    mem_data_d = '0;
    if ((st_q == StIdle) && !mem_op) begin
      wb_load = 1'b1;
    end else if (busy_done) begin
      wb_load = 1'b1;
      if (sram.sram_ready) begin
        mem_data_d = we_q ? 32'd0 : sram.sram_rdata;
      end else begin
        wb_en_d    = 1'b0;
        mem_read_d = 1'b0;
      end
    end
  end

  mem_stage_sram_mem_wb_reg u_mem_wb_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (wb_load),
    .wb_enable      (wb_en_d),
    .mem_read       (mem_read_d),
    .dest           (dest),
    .alu_result     (alu_out),
    .mem_data       (mem_data_d),
    .wb_enable_out  (wb_enable_out),
    .mem_read_out   (mem_read_out),
    .dest_out       (dest_out),
    .alu_result_out (alu_result_out),
    .mem_data_out   (mem_data_out)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  localparam int unsigned AddrW   = 16;
  localparam int unsigned Timeout = 255;

  // Hand-computed word addresses for the byte addresses used below.
`ifdef MEM_BASE_OFFSET_EN
  localparam logic [15:0] A1024 = 16'd0;
  localparam logic [15:0] A1032 = 16'd2;
  localparam logic [15:0] A1040 = 16'd4;
  localparam logic [15:0] A1048 = 16'd6;
  localparam logic [15:0] A1056 = 16'd8;
`else
  localparam logic [15:0] A1024 = 16'd256;
  localparam logic [15:0] A1032 = 16'd258;
  localparam logic [15:0] A1040 = 16'd260;
  localparam logic [15:0] A1048 = 16'd262;
  localparam logic [15:0] A1056 = 16'd264;
`endif

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_enable, mem_read_enable, mem_write_enable;
  logic [3:0]  dest;
  logic [31:0] alu_out, Val_Rm;
  logic        freeze, wb_enable_out, mem_read_out, mem_err;
  logic [3:0]  dest_out;
  logic [31:0] alu_result_out, mem_data_out;

  int checks = 0;
  int errors = 0;
  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  mem_stage_sram_if #(.ADDR_W(AddrW)) sram_bus ();

  mem_stage_sram #(
    .ADDR_W    (AddrW),
    .BASE_ADDR (1024),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_enable        (wb_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .dest             (dest),
    .alu_out          (alu_out),
    .Val_Rm           (Val_Rm),
    .sram             (sram_bus),
    .freeze           (freeze),
    .wb_enable_out    (wb_enable_out),
    .mem_read_out     (mem_read_out),
    .dest_out         (dest_out),
    .alu_result_out   (alu_result_out),
    .mem_data_out     (mem_data_out),
    .mem_err          (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr, input logic [3:0] d,
                       input logic [31:0] alu, input logic [31:0] val);
    wb_enable        = wb;
    mem_read_enable  = rd;
    mem_write_enable = wr;
    dest             = d;
    alu_out          = alu;
    Val_Rm           = val;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic set_sram(input logic rdy, input logic [31:0] rdata);
    sram_bus.sram_ready = rdy;
    sram_bus.sram_rdata = rdata;
  endtask

  // Monitor: every writeback pulse and every new SRAM request is checked against the queues.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_enable_out || mem_read_out) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", {31'd0, wb_enable_out}, 32'd0);
        end else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          chk("wb_enable_out", {31'd0, wb_enable_out}, {31'd0, e.wb});
          chk("mem_read_out", {31'd0, mem_read_out}, {31'd0, e.mr});
          chk("dest_out", {28'd0, dest_out}, {28'd0, e.dest});
          chk("alu_result_out", alu_result_out, e.alu);
          chk("mem_data_out", mem_data_out, e.data);
        end
      end
      if (sram_bus.sram_req && !prev_req) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'd1, 32'd0);
        end else begin
          req_exp_t r;
          r = req_q.pop_front();
          chk("sram_we", {31'd0, sram_bus.sram_we}, {31'd0, r.we});
          chk("sram_addr", {16'd0, sram_bus.sram_addr}, {16'd0, r.addr});
          chk("sram_wdata", sram_bus.sram_wdata, r.wdata);
        end
      end
    end
    prev_req <= sram_bus.sram_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcnt;
    bit done;

    rst = 1'b1;
    nop();
    set_sram(1'b0, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_req", {31'd0, sram_bus.sram_req}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_wb", {31'd0, wb_enable_out}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_addr", {16'd0, sram_bus.sram_addr}, 32'd0);
    tick();

    // 1. ALU pass-through.
    drive(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'd0);
    wb_q.push_back('{wb: 1'b1, mr: 1'b0, dest: 4'd3, alu: 32'h55, data: 32'd0});
    @(negedge clk);
    chk("alu_freeze", {31'd0, freeze}, 32'd0);
    tick();
    nop();
    @(negedge clk);
    chk("alu_freeze_after", {31'd0, freeze}, 32'd0);
    tick();

    // 2. Load, ready on the 4th BUSY cycle.
    drive(1'b1, 1'b1, 1'b0, 4'd5, 32'd1032, 32'd0);
    req_q.push_back('{we: 1'b0, addr: A1032, wdata: 32'd0});
    wb_q.push_back('{wb: 1'b1, mr: 1'b1, dest: 4'd5, alu: 32'd1032, data: 32'hDEADBEEF});
    fcnt = 0;
    repeat (4) begin
      @(negedge clk);
      fcnt += int'(freeze);
      tick();
    end
    set_sram(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    fcnt += int'(freeze);
    tick();
    nop();
    set_sram(1'b0, 32'd0);
    chk("load_freeze_cycles", fcnt, 32'd4);
    @(negedge clk);
    chk("load_req_dropped", {31'd0, sram_bus.sram_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("load_single_wb", {31'd0, wb_enable_out}, 32'd0);
    tick();

    // 3. Store, ready on the first BUSY cycle.
    drive(1'b0, 1'b0, 1'b1, 4'd1, 32'd1024, 32'h1234);
    req_q.push_back('{we: 1'b1, addr: A1024, wdata: 32'h1234});
    fcnt = 0;
    @(negedge clk);
    fcnt += int'(freeze);
    tick();
    set_sram(1'b1, 32'hCAFE0000);
    @(negedge clk);
    fcnt += int'(freeze);
    tick();
    nop();
    set_sram(1'b0, 32'd0);
    // Cycles spent in MEM: frozen cycles plus the completing one.
    chk("store_mem_cycles", fcnt + 1, 32'd2);
    @(negedge clk);
    chk("store_wb", {31'd0, wb_enable_out}, 32'd0);
    chk("store_mem_read_out", {31'd0, mem_read_out}, 32'd0);
    tick();

    // 4. Load that never completes.
    drive(1'b1, 1'b1, 1'b0, 4'd7, 32'd1040, 32'd0);
    req_q.push_back('{we: 1'b0, addr: A1040, wdata: 32'd0});
    fcnt = 0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (freeze) fcnt++;
      else done = 1'b1;
      tick();
    end
    nop();
    chk("timeout_freeze_cycles", fcnt, 32'd256);
    @(negedge clk);
    chk("timeout_err", {31'd0, mem_err}, 32'd1);
    chk("timeout_wb", {31'd0, wb_enable_out}, 32'd0);
    chk("timeout_data", mem_data_out, 32'd0);
    chk("timeout_req", {31'd0, sram_bus.sram_req}, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("timeout_err_sticky", {31'd0, mem_err}, 32'd1);
    tick();

    // 5. Reset during the 2nd BUSY cycle.
    drive(1'b1, 1'b1, 1'b0, 4'd2, 32'd1048, 32'd0);
    req_q.push_back('{we: 1'b0, addr: A1048, wdata: 32'd0});
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    nop();
    @(negedge clk);
    chk("rst_busy_req", {31'd0, sram_bus.sram_req}, 32'd0);
    chk("rst_busy_addr", {16'd0, sram_bus.sram_addr}, 32'd0);
    chk("rst_busy_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_busy_wb", {31'd0, wb_enable_out}, 32'd0);
    chk("rst_busy_alu", alu_result_out, 32'd0);
    chk("rst_busy_err", {31'd0, mem_err}, 32'd0);
    tick();

    // 6. Read and write both set; then sram_ready while idle.
    drive(1'b1, 1'b1, 1'b1, 4'd9, 32'd1056, 32'hABCD);
    req_q.push_back('{we: 1'b0, addr: A1056, wdata: 32'hABCD});
    wb_q.push_back('{wb: 1'b1, mr: 1'b1, dest: 4'd9, alu: 32'd1056, data: 32'h0BADF00D});
    @(negedge clk);
    tick();
    set_sram(1'b1, 32'h0BADF00D);
    @(negedge clk);
    chk("rw_done_freeze", {31'd0, freeze}, 32'd0);
    tick();
    nop();
    set_sram(1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("idle_ready_req", {31'd0, sram_bus.sram_req}, 32'd0);
    chk("idle_ready_freeze", {31'd0, freeze}, 32'd0);
    chk("idle_ready_data", mem_data_out, 32'd0);
    chk("idle_ready_wb", {31'd0, wb_enable_out}, 32'd0);
    tick();
    set_sram(1'b0, 32'd0);
    repeat (2) tick();

    chk("wb_queue_empty", wb_q.size(), 32'd0);
    chk("req_queue_empty", req_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
